// File: rtl/alu_result_commit_pkg.sv
// alu_result_commit_pkg
// Shared definitions for the ALU result commit stage: datapath width,
// register index width, flag bit positions inside a CNZV nibble and the
// ARM condition-code encoding. No ports.
package alu_result_commit_pkg;

  localparam int WordWidth = 32;
  localparam int RegIdxW   = 4;
  localparam logic [3:0] BranchReg = 4'd15;

  // Flag bit positions inside {C,N,Z,V}
  localparam int FlagC = 3;
  localparam int FlagN = 2;
  localparam int FlagZ = 1;
  localparam int FlagV = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_t;

endpackage

// File: rtl/alu_result_commit_if.sv
// alu_result_commit_if
// Result handshake between the ALU (master) and the commit stage (slave).
//   in_Valid      ALU result present this cycle (master -> slave)
//   out_Ready     commit stage can accept       (slave -> master)
//   in_Y          result data
//   in_CNZV       result flags {C,N,Z,V}
//   in_Writeback  result targets in_Rd
//   in_Set_cond   instruction updates the flags
//   in_Rd         destination register
//   in_Cond       ARM condition field
interface alu_result_commit_if
  import alu_result_commit_pkg::*;
#(
  parameter int DataWidth = WordWidth
);
  logic                 in_Valid;
  logic                 out_Ready;
  logic [DataWidth-1:0] in_Y;
  logic [3:0]           in_CNZV;
  logic                 in_Writeback;
  logic                 in_Set_cond;
  logic [RegIdxW-1:0]   in_Rd;
  logic [3:0]           in_Cond;

  modport master (
    output in_Valid, in_Y, in_CNZV, in_Writeback, in_Set_cond, in_Rd, in_Cond,
    input  out_Ready
  );

  modport slave (
    input  in_Valid, in_Y, in_CNZV, in_Writeback, in_Set_cond, in_Rd, in_Cond,
    output out_Ready
  );
endinterface

// File: rtl/alu_result_commit_cond_check.sv
// alu_result_commit_cond_check
// Combinational ARM condition evaluator, reusable by the branch unit.
//   in_Cond   condition field
//   in_CNZV   flags {C,N,Z,V}
//   out_Pass  1 when the condition holds
module alu_result_commit_cond_check
  import alu_result_commit_pkg::*;
(
  input  logic [3:0] in_Cond,
  input  logic [3:0] in_CNZV,
  output logic       out_Pass
);

  logic c, n, z, v;

  assign c = in_CNZV[FlagC];
  assign n = in_CNZV[FlagN];
  assign z = in_CNZV[FlagZ];
  assign v = in_CNZV[FlagV];

  always_comb begin
    out_Pass = 1'b0;
    case (cond_t'(in_Cond))
      COND_EQ: out_Pass = z;
      COND_NE: out_Pass = !z;
      COND_CS: out_Pass = c;
      COND_CC: out_Pass = !c;
      COND_MI: out_Pass = n;
      COND_PL: out_Pass = !n;
      COND_VS: out_Pass = v;
      COND_VC: out_Pass = !v;
      COND_HI: out_Pass = c && !z;
      COND_LS: out_Pass = !c || z;
      COND_GE: out_Pass = (n == v);
      COND_LT: out_Pass = (n != v);
      COND_GT: out_Pass = !z && (n == v);
      COND_LE: out_Pass = z || (n != v);
      COND_AL: out_Pass = 1'b1;
      default: out_Pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_result_commit.sv
// alu_result_commit
// Consumer end of the ALU: captures one result into S1, evaluates its
// condition against the architectural flags and commits it to the register
// file / flags one cycle after acceptance.
//   in_Clk, in_Reset           clock, synchronous active-high reset
//   alu                        result handshake (slave side)
//   in_Hold                    hazard unit freezes the commit stage
//   in_RaddrA/B, out_RdataA/B  two combinational read ports with bypass
//   out_CNZV                   architectural flags (feeds ALU in_CNZV)
//   out_Retire                 pulse per retired instruction
//   out_Branch, out_Branch_target  pulse + value on executed write to R15
//   out_Retired_count          wrapping retired-instruction counter
module alu_result_commit
  import alu_result_commit_pkg::*;
#(
  parameter int         DataWidth  = WordWidth,
  parameter int         NumRegs    = 16,
  parameter logic [3:0] ResetFlags = 4'b0000
)(
  input  logic                 in_Clk,
  input  logic                 in_Reset,
  alu_result_commit_if.slave   alu,
  input  logic                 in_Hold,
  input  logic [RegIdxW-1:0]   in_RaddrA,
  input  logic [RegIdxW-1:0]   in_RaddrB,
  output logic [DataWidth-1:0] out_RdataA,
  output logic [DataWidth-1:0] out_RdataB,
  output logic [3:0]           out_CNZV,
  output logic                 out_Retire,
  output logic                 out_Branch,
  output logic [DataWidth-1:0] out_Branch_target,
  output logic [31:0]          out_Retired_count
);

  logic                 s1_v;
  logic [DataWidth-1:0] s1_y;
  logic [3:0]           s1_cnzv;
  logic                 s1_wb;
  logic                 s1_sc;
  logic [RegIdxW-1:0]   s1_rd;
  logic [3:0]           s1_cond;

  logic [DataWidth-1:0] regs [NumRegs];

  logic accept;
  logic commit;
  logic pass;
  logic wr_en;
  logic flag_en;

  assign alu.out_Ready = !s1_v || !in_Hold;
  assign accept        = alu.in_Valid && alu.out_Ready;
  // Reset discards S1, so nothing commits (or bypasses) in a reset cycle.
  assign commit        = s1_v && !in_Hold && !in_Reset;
  assign wr_en         = commit && pass && s1_wb;
  assign flag_en       = commit && pass && s1_sc;

  alu_result_commit_cond_check u_cond_check (
    .in_Cond  (s1_cond),
    .in_CNZV  (out_CNZV),
    .out_Pass (pass)
  );

  // Same-cycle write forwarding so the operand stage sees the new value.
  assign out_RdataA = (wr_en && (s1_rd == in_RaddrA)) ? s1_y : regs[in_RaddrA];
  assign out_RdataB = (wr_en && (s1_rd == in_RaddrB)) ? s1_y : regs[in_RaddrB];

  always_ff @(posedge in_Clk) begin
    if (in_Reset) begin
      s1_v              <= 1'b0;
      s1_y              <= '0;
      s1_cnzv           <= '0;
      s1_wb             <= 1'b0;
      s1_sc             <= 1'b0;
      s1_rd             <= '0;
      s1_cond           <= '0;
      out_CNZV          <= ResetFlags;
      out_Retire        <= 1'b0;
      out_Branch        <= 1'b0;
      out_Branch_target <= '0;
      out_Retired_count <= '0;
      for (int i = 0; i < NumRegs; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (accept) begin
        s1_v    <= 1'b1;
        s1_y    <= alu.in_Y;
        s1_cnzv <= alu.in_CNZV;
        s1_wb   <= alu.in_Writeback;
        s1_sc   <= alu.in_Set_cond;
        s1_rd   <= alu.in_Rd;
        s1_cond <= alu.in_Cond;
      end else if (commit) begin
        s1_v <= 1'b0;
      end

      out_Retire <= commit;
      out_Branch <= wr_en && (s1_rd == BranchReg);

      if (commit) begin
        out_Retired_count <= out_Retired_count + 32'd1;
      end
      if (wr_en) begin
        regs[s1_rd] <= s1_y;
      end
      if (wr_en && (s1_rd == BranchReg)) begin
        out_Branch_target <= s1_y;
      end
      if (flag_en) begin
        out_CNZV <= s1_cnzv;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_commit.sv
module tb_alu_result_commit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold = 1'b0;
  logic [3:0]  raddr_a = 4'd0;
  logic [3:0]  raddr_b = 4'd0;
  logic [31:0] rdata_a, rdata_b, btarget;
  logic [3:0]  cnzv;
  logic        retire, branch;
  logic [31:0] rcount;

  int total = 0;
  int bad   = 0;

  alu_result_commit_if #(.DataWidth(32)) bus ();

  alu_result_commit dut (
    .in_Clk            (clk),
    .in_Reset          (rst),
    .alu               (bus),
    .in_Hold           (hold),
    .in_RaddrA         (raddr_a),
    .in_RaddrB         (raddr_b),
    .out_RdataA        (rdata_a),
    .out_RdataB        (rdata_b),
    .out_CNZV          (cnzv),
    .out_Retire        (retire),
    .out_Branch        (branch),
    .out_Branch_target (btarget),
    .out_Retired_count (rcount)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] y;
    logic [3:0]  f;
    logic        wb;
    logic        sc;
    logic [3:0]  rd;
    logic [3:0]  cond;
  } txn_t;

  txn_t        pend_q[$];
  logic [31:0] m_regs [16];
  logic [3:0]  m_flags;
  logic [31:0] m_count;
  logic        m_retire, m_branch;
  logic [31:0] m_btarget;

  function automatic bit cond_ok(logic [3:0] c, logic [3:0] fl);
    bit fc, fn, fz, fv;
    fc = fl[3]; fn = fl[2]; fz = fl[1]; fv = fl[0];
    case (c)
      4'd0:  return fz;
      4'd1:  return !fz;
      4'd2:  return fc;
      4'd3:  return !fc;
      4'd4:  return fn;
      4'd5:  return !fn;
      4'd6:  return fv;
      4'd7:  return !fv;
      4'd8:  return fc && !fz;
      4'd9:  return !fc || fz;
      4'd10: return fn == fv;
      4'd11: return fn != fv;
      4'd12: return !fz && (fn == fv);
      4'd13: return fz || (fn != fv);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_ready();
    return (pend_q.size() == 0) || !hold;
  endfunction

  function automatic logic [31:0] m_read(logic [3:0] a);
    if (!rst && pend_q.size() != 0 && !hold && pend_q[0].wb &&
        pend_q[0].rd == a && cond_ok(pend_q[0].cond, m_flags))
      return pend_q[0].y;
    return m_regs[a];
  endfunction

  task automatic model_edge();
    bit   rdy, com;
    txn_t t;
    rdy = m_ready();
    com = (pend_q.size() != 0) && !hold;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_flags = 4'b0000; m_count = 0; m_retire = 0; m_branch = 0; m_btarget = 0;
      pend_q.delete();
    end else begin
      m_retire = com;
      m_branch = 0;
      if (com) begin
        t = pend_q.pop_front();
        m_count = m_count + 1;
        if (cond_ok(t.cond, m_flags)) begin
          if (t.wb) begin
            m_regs[t.rd] = t.y;
            if (t.rd == 4'd15) begin
              m_branch = 1; m_btarget = t.y;
            end
          end
          if (t.sc) m_flags = t.f;
        end
      end
      if (bus.in_Valid && rdy) begin
        t.y = bus.in_Y; t.f = bus.in_CNZV; t.wb = bus.in_Writeback;
        t.sc = bus.in_Set_cond; t.rd = bus.in_Rd; t.cond = bus.in_Cond;
        pend_q.push_back(t);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(logic [31:0] y, logic [3:0] f, logic wb, logic sc,
                       logic [3:0] rd, logic [3:0] cond);
    bus.in_Valid = 1'b1; bus.in_Y = y; bus.in_CNZV = f; bus.in_Writeback = wb;
    bus.in_Set_cond = sc; bus.in_Rd = rd; bus.in_Cond = cond;
  endtask

  task automatic idle();
    bus.in_Valid = 1'b0; bus.in_Y = 'x; bus.in_CNZV = 'x; bus.in_Writeback = 'x;
    bus.in_Set_cond = 'x; bus.in_Rd = 'x; bus.in_Cond = 'x;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; hold = 0; idle();
    tick(); tick();
    rst = 0;
    #1;
    total++; if (cnzv !== 4'b0000) begin bad++; $display("FAIL reset_cnzv got=%h exp=0", cnzv); end
    total++; if (rcount !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", rcount); end
    total++; if (retire !== 1'b0 || branch !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", retire, branch); end
    total++; if (btarget !== 32'd0) begin bad++; $display("FAIL reset_btarget got=%h exp=0", btarget); end
    total++; if (bus.out_Ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.out_Ready); end
    for (int a = 0; a < 16; a++) begin
      raddr_a = a[3:0]; #1;
      total++; if (rdata_a !== 32'd0) begin bad++; $display("FAIL reset_reg%0d got=%h exp=0", a, rdata_a); end
    end
  endtask

  task automatic test_basic();
    drive(32'd5, 4'b0000, 1, 1, 4'd1, 4'd14);
    tick();
    idle(); raddr_a = 4'd1;
    tick();
    total++; if (rdata_a !== 32'd5) begin bad++; $display("FAIL basic_r1 got=%h exp=5", rdata_a); end
    total++; if (cnzv !== 4'b0000) begin bad++; $display("FAIL basic_cnzv got=%h exp=0", cnzv); end
    total++; if (retire !== 1'b1) begin bad++; $display("FAIL basic_retire got=%b exp=1", retire); end
    total++; if (rcount !== 32'd1) begin bad++; $display("FAIL basic_count got=%0d exp=1", rcount); end
    tick();
    total++; if (retire !== 1'b0) begin bad++; $display("FAIL basic_retire_end got=%b exp=0", retire); end
  endtask

  task automatic test_cond_fail();
    logic [31:0] start;
    start = m_count;
    drive(32'd0, 4'b0010, 0, 1, 4'd0, 4'd14);
    tick();
    drive(32'd7, 4'b0000, 1, 0, 4'd2, 4'd1);
    tick();
    idle(); raddr_a = 4'd2;
    tick();
    total++; if (rdata_a !== m_regs[2] || rdata_a !== 32'd0) begin bad++; $display("FAIL ne_r2 got=%h exp=0", rdata_a); end
    total++; if (cnzv !== 4'b0010) begin bad++; $display("FAIL ne_cnzv got=%h exp=2", cnzv); end
    total++; if (rcount !== start + 32'd2) begin bad++; $display("FAIL ne_count got=%0d exp=%0d", rcount, start + 2); end
    total++; if (retire !== 1'b1) begin bad++; $display("FAIL ne_retire got=%b exp=1", retire); end
  endtask

  task automatic test_hold();
    logic [31:0] r3_before, yb;
    r3_before = m_regs[3];
    yb = $urandom;
    drive(32'd9, 4'b0000, 1, 0, 4'd3, 4'd14);
    tick();
    idle(); hold = 1; raddr_a = 4'd3; raddr_b = 4'd6;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (bus.out_Ready !== 1'b0) begin bad++; $display("FAIL hold_ready%0d got=%b exp=0", i, bus.out_Ready); end
      tick();
      total++; if (retire !== 1'b0) begin bad++; $display("FAIL hold_retire%0d got=%b exp=0", i, retire); end
      total++; if (rdata_a !== r3_before) begin bad++; $display("FAIL hold_r3_%0d got=%h exp=%h", i, rdata_a, r3_before); end
    end
    hold = 0;
    drive(yb, 4'b0000, 1, 0, 4'd6, 4'd14);
    #1;
    total++; if (bus.out_Ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", bus.out_Ready); end
    tick();
    idle();
    total++; if (retire !== 1'b1) begin bad++; $display("FAIL release_retire got=%b exp=1", retire); end
    total++; if (rdata_a !== 32'd9) begin bad++; $display("FAIL release_r3 got=%h exp=9", rdata_a); end
    tick();
    total++; if (retire !== 1'b1) begin bad++; $display("FAIL second_retire got=%b exp=1", retire); end
    total++; if (rdata_b !== yb) begin bad++; $display("FAIL second_r6 got=%h exp=%h", rdata_b, yb); end
  endtask

  task automatic test_branch();
    drive(32'h100, 4'b0000, 1, 0, 4'd15, 4'd14);
    tick();
    idle();
    tick();
    total++; if (branch !== 1'b1) begin bad++; $display("FAIL branch_pulse got=%b exp=1", branch); end
    total++; if (btarget !== 32'h100) begin bad++; $display("FAIL branch_target got=%h exp=100", btarget); end
    raddr_a = 4'd15; #1;
    total++; if (rdata_a !== 32'h100) begin bad++; $display("FAIL branch_r15 got=%h exp=100", rdata_a); end
    tick();
    total++; if (branch !== 1'b0) begin bad++; $display("FAIL branch_end got=%b exp=0", branch); end
  endtask

  task automatic test_bypass();
    drive(32'hDEAD, 4'b0000, 1, 0, 4'd4, 4'd14);
    tick();
    idle(); raddr_b = 4'd4;
    #1;
    total++; if (rdata_b !== 32'hDEAD) begin bad++; $display("FAIL bypass_b got=%h exp=dead", rdata_b); end
    tick();
    total++; if (rdata_b !== 32'hDEAD) begin bad++; $display("FAIL bypass_stored got=%h exp=dead", rdata_b); end
  endtask

  task automatic test_reset_mid();
    drive(32'd1, 4'b1111, 1, 1, 4'd5, 4'd14);
    tick();
    idle(); rst = 1; raddr_a = 4'd5;
    tick();
    rst = 0;
    total++; if (rdata_a !== 32'd0) begin bad++; $display("FAIL rstmid_r5 got=%h exp=0", rdata_a); end
    total++; if (cnzv !== 4'b0000) begin bad++; $display("FAIL rstmid_cnzv got=%h exp=0", cnzv); end
    total++; if (rcount !== 32'd0) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", rcount); end
    total++; if (retire !== 1'b0) begin bad++; $display("FAIL rstmid_retire got=%b exp=0", retire); end
    total++; if (bus.out_Ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", bus.out_Ready); end
    tick();
    total++; if (retire !== 1'b0 || rdata_a !== 32'd0) begin bad++; $display("FAIL rstmid_discard got=%b/%h exp=0/0", retire, rdata_a); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      hold = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) != 0)
        drive($urandom, 4'($urandom), 1'($urandom), 1'($urandom),
              4'($urandom), 4'($urandom));
      else
        idle();
      raddr_a = 4'($urandom); raddr_b = 4'($urandom);
      #1;
      total++; if (bus.out_Ready !== m_ready()) begin bad++; $display("FAIL rnd_ready@%0d got=%b exp=%b", n, bus.out_Ready, m_ready()); end
      total++; if (rdata_a !== m_read(raddr_a)) begin bad++; $display("FAIL rnd_rdata_a@%0d got=%h exp=%h", n, rdata_a, m_read(raddr_a)); end
      total++; if (rdata_b !== m_read(raddr_b)) begin bad++; $display("FAIL rnd_rdata_b@%0d got=%h exp=%h", n, rdata_b, m_read(raddr_b)); end
      tick();
      total++; if (retire !== m_retire) begin bad++; $display("FAIL rnd_retire@%0d got=%b exp=%b", n, retire, m_retire); end
      total++; if (branch !== m_branch) begin bad++; $display("FAIL rnd_branch@%0d got=%b exp=%b", n, branch, m_branch); end
      total++; if (btarget !== m_btarget) begin bad++; $display("FAIL rnd_btarget@%0d got=%h exp=%h", n, btarget, m_btarget); end
      total++; if (cnzv !== m_flags) begin bad++; $display("FAIL rnd_cnzv@%0d got=%h exp=%h", n, cnzv, m_flags); end
      total++; if (rcount !== m_count) begin bad++; $display("FAIL rnd_count@%0d got=%0d exp=%0d", n, rcount, m_count); end
    end
    idle(); hold = 0;
    for (int a = 0; a < 16; a++) begin
      raddr_a = a[3:0]; #1;
      total++; if (rdata_a !== m_read(raddr_a)) begin bad++; $display("FAIL rnd_final_r%0d got=%h exp=%h", a, rdata_a, m_read(raddr_a)); end
    end
  endtask

  initial begin
    idle();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_flags = 0; m_count = 0; m_retire = 0; m_branch = 0; m_btarget = 0;
    #1;
    test_reset();
    test_basic();
    test_cond_fail();
    test_hold();
    test_branch();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_commit.md
Name: alu_result_commit

Overview:
- Consumer end of the ALU interface: captures ALU results (Y, CNZV, Writeback, Set_cond) plus destination and condition fields.
- Evaluates the instruction's condition code against the architectural flags, then commits the result to the register file and the flags register.
- out_CNZV feeds back as the ALU's in_CNZV.
- Two register read ports supply in_Rn/in_Op2 sources to the operand stage.

Parameters:
- DataWidth, `WordWidth (from Def_StructureParameter.v): datapath width.
- NumRegs, 16: architectural registers; index width 4.
- ResetFlags, 4'b0000: CNZV value after reset.

Ports:
- in_Clk  input  1  clock, all state on rising edge.
- in_Reset  input  1  synchronous, active-high reset.
- in_Valid  input  1  ALU result present this cycle.
- out_Ready  output  1  result accepted when in_Valid && out_Ready.
- in_Y  input  DataWidth  ALU result.
- in_CNZV  input  4  ALU flags, order {C,N,Z,V} (bit3=C, bit0=V).
- in_Writeback  input  1  result targets Rd.
- in_Set_cond  input  1  instruction updates flags.
- in_Rd  input  4  destination register.
- in_Cond  input  4  ARM condition field.
- in_Hold  input  1  hazard unit freezes the commit stage.
- in_RaddrA, in_RaddrB  input  4  read addresses.
- out_RdataA, out_RdataB  output  DataWidth  read data, combinational.
- out_CNZV  output  4  architectural flags.
- out_Retire  output  1  one-cycle pulse per retired instruction, whether executed or condition-failed.
- out_Branch  output  1  pulse: executed write to R15.
- out_Branch_target  output  DataWidth  R15 value written; valid with out_Branch.
- out_Retired_count  output  32  retired-instruction counter.

Behaviour:
- Stage S1: capture register with valid bit s1_v.
  - out_Ready = !s1_v || !in_Hold.
  - On handshake, S1 loads all in_* fields and sets s1_v.
  - If s1_v && !in_Hold && no new handshake, s1_v clears.
- Commit occurs in any cycle with s1_v && !in_Hold; latency is one cycle from acceptance to architectural update (visible the next cycle).
- Condition pass is evaluated against out_CNZV at commit:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 4'b1111 never.
- Pass and S1 Writeback: reg[Rd] <= Y.
- Pass and S1 Set_cond: out_CNZV <= S1 CNZV.
- Fail: no register or flag update.
- Every commit, pass or fail: pulses out_Retire and increments out_Retired_count. The counter wraps 0xFFFFFFFF->0.
- Pass and Writeback with Rd==15: pulses out_Branch with out_Branch_target=Y, and R15 is still written.
- Read ports bypass: if a commit write to address X occurs this cycle, a read of X returns the new Y. Otherwise the port returns stored contents.
- in_Hold asserted with s1_v=1: S1 contents are held unchanged and out_Retire is 0.
- in_Valid while out_Ready=0: no capture; the producer holds its inputs.
- Reset, including mid-operation: s1_v=0, all registers 0, out_CNZV=ResetFlags, count 0, out_Retire=0, out_Branch=0, out_Branch_target=0. A result in S1 is discarded and not committed. out_Ready=1 in the first cycle after reset.
- X on in_* with in_Valid=0 must not affect state.

Decomposition:
- Shared include (Def_CondType.v, alongside Def_ALUType.v): condition-code constants (`Cond_EQ ... `Cond_NV) and flag bit positions (`Flag_C=3, `Flag_N=2, `Flag_Z=1, `Flag_V=0).
- One combinational sub-module cond_check (in_Cond, in_CNZV -> out_Pass), reusable by the branch unit.
- Register file stays inline.

Test Plan:
- Reset, then accept Y=5, Rd=1, Writeback=1, Cond=AL, Set_cond=1, CNZV=0000 -> next cycle out_RdataA(addr 1)=5, out_CNZV=0000, out_Retire pulse, count=1.
- Commit Y=0, Set_cond=1, CNZV=0010, then Cond=NE, Y=7, Rd=2 -> R2 unchanged (0), out_CNZV=0010, count increments by 2.
- Hold: S1 valid, in_Hold=1 for 3 cycles -> out_Ready=0, no retire, R3 unchanged. Release -> R3=9 one cycle later, and a second in_Valid is accepted on the release cycle.
- Write Rd=15, Y=32'h100, Cond=AL -> out_Branch=1 for exactly one cycle, out_Branch_target=32'h100.
- Bypass: commit R4=32'hDEAD while in_RaddrB=4 -> out_RdataB=32'hDEAD in the same cycle.
- Assert in_Reset with S1 holding Y=1, Rd=5 -> R5=0, out_CNZV=0000, count=0, no out_Retire pulse.
